irq_aggregator: RTL and testbench

- Collects the SoC interrupt lines (DMA x2, sensor controller, EPU) and presents one prioritised request plus a source ID to the CPU wrapper.
- Sits directly downstream of the interrupt sources and upstream of the CPU interrupt input.
- Provides per-source pending latching (edge or level), enable masking, and a claim/complete handshake.
- Programmed through a small single-cycle register port driven by the CPU-side bus bridge.

---
 rtl/irq_aggregator.sv | 142 ++++++++++++++
 tb/tb_irq_aggregator.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/irq_aggregator.sv
// Four-source interrupt aggregator with edge/level pending latches,
// enable masking, fixed priority and a claim/complete register port.
module irq_aggregator #(
  parameter int                 NUM_SRC   = 4,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = 4'b0011,
  parameter int                 ID_W      = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_i,
  input  logic               reg_req_i,
  input  logic               reg_we_i,
  input  logic [3:0]         reg_addr_i,
  input  logic [31:0]        reg_wdata_i,
  output logic [31:0]        reg_rdata_o,
  output logic               reg_ack_o,
  output logic               int_o,
  output logic [ID_W-1:0]    int_id_o
);

  logic [NUM_SRC-1:0] irq_q;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] en_q, en_d;
  logic [NUM_SRC-1:0] svc_q, svc_d;
  logic               busy_q, busy_d;
  logic [NUM_SRC-1:0] elig, win_oh, edge_set, clr;
  logic [ID_W-1:0]    win_id, svc_id;
  logic [ID_W-1:0]    int_id_q;
  logic               int_q, int_d;
  logic               ack_q;
  logic [31:0]        rdata_q, rdata_d;
  logic               rd, wr;
  logic               a_pend, a_en, a_claim, a_stat;
  logic               claim_ok, cmpl_ok;
  logic               unused_wdata;

  assign unused_wdata = ^reg_wdata_i[31:NUM_SRC];

  assign rd      = reg_req_i & ~reg_we_i;
  assign wr      = reg_req_i & reg_we_i;
  assign a_pend  = (reg_addr_i == 4'h0);
  assign a_en    = (reg_addr_i == 4'h4);
  assign a_claim = (reg_addr_i == 4'h8);
  assign a_stat  = (reg_addr_i == 4'hC);

  assign elig     = pend_q & en_q & ~svc_q;
  assign edge_set = irq_i & ~irq_q;

  // Ascending scan: the highest-index eligible source is kept.
  always_comb begin
    win_oh = '0;
    win_id = '0;
    svc_id = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (elig[k]) begin
        win_oh    = '0;
        win_oh[k] = 1'b1;
        win_id    = ID_W'(k + 1);
      end
      if (svc_q[k]) svc_id = ID_W'(k + 1);
    end
  end

  assign claim_ok = rd & a_claim & ~busy_q & (|elig);
  assign cmpl_ok  = wr & a_claim & busy_q & (svc_id != '0)
                  & (reg_wdata_i[ID_W-1:0] == svc_id);

  always_comb begin
    clr = '0;
    if (wr && a_pend) clr = reg_wdata_i[NUM_SRC-1:0];
    if (claim_ok)     clr = clr | win_oh;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (EDGE_MASK[k])
        pend_d[k] = edge_set[k] | (pend_q[k] & ~clr[k]);
      else
        pend_d[k] = irq_i[k];
    end
  end

  always_comb begin
    en_d   = en_q;
    svc_d  = svc_q;
    busy_d = busy_q;
    if (wr && a_en) en_d = reg_wdata_i[NUM_SRC-1:0];
    if (claim_ok) begin
      svc_d  = svc_q | win_oh;
      busy_d = 1'b1;
    end else if (cmpl_ok) begin
      svc_d  = '0;
      busy_d = 1'b0;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (rd) begin
      unique case (1'b1)
        a_pend:  rdata_d[NUM_SRC-1:0] = pend_q;
        a_en:    rdata_d[NUM_SRC-1:0] = en_q;
        a_claim: rdata_d[ID_W-1:0]    = claim_ok ? win_id : '0;
        a_stat: begin
          rdata_d[8]           = busy_q;
          rdata_d[NUM_SRC-1:0] = svc_q;
        end
        default: rdata_d = '0;
      endcase
    end
  end

  // A claim in flight masks the request in the same edge it is taken.
  assign int_d = (|elig) & ~busy_q & ~claim_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_q    <= '0;
      pend_q   <= '0;
      en_q     <= '0;
      svc_q    <= '0;
      busy_q   <= 1'b0;
      int_q    <= 1'b0;
      int_id_q <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      irq_q    <= irq_i;
      pend_q   <= pend_d;
      en_q     <= en_d;
      svc_q    <= svc_d;
      busy_q   <= busy_d;
      int_q    <= int_d;
      int_id_q <= win_id;
      ack_q    <= reg_req_i;
      rdata_q  <= rdata_d;
    end
  end

  assign reg_rdata_o = rdata_q;
  assign reg_ack_o   = ack_q;
  assign int_o       = int_q;
  assign int_id_o    = int_id_q;

endmodule

// File: tb/tb_irq_aggregator.sv
// Directed bench for irq_aggregator: latching, priority, masking,
// claim/complete handshake and asynchronous reset.
module tb_irq_aggregator;

  logic        clk;
  logic        rst;
  logic [3:0]  irq;
  logic        req;
  logic        we;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        int_o;
  logic [2:0]  int_id;

  int n_run;
  int n_fail;

  irq_aggregator dut (
    .clk         (clk),
    .rst         (rst),
    .irq_i       (irq),
    .reg_req_i   (req),
    .reg_we_i    (we),
    .reg_addr_i  (addr),
    .reg_wdata_i (wdata),
    .reg_rdata_o (rdata),
    .reg_ack_o   (ack),
    .int_o       (int_o),
    .int_id_o    (int_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus(input logic w, input logic [3:0] a,
                     input logic [31:0] d, output logic [31:0] r);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    chk("ack", 32'(ack), 32'd1);
    r = rdata;
  endtask

  task automatic rd(input string tag, input logic [3:0] a,
                    input logic [31:0] exp);
    logic [31:0] r;
    bus(1'b0, a, 32'd0, r);
    chk(tag, r, exp);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus(1'b1, a, d, r);
  endtask

  task automatic pulse(input int k);
    @(negedge clk);
    irq[k] = 1'b1;
    @(negedge clk);
    irq[k] = 1'b0;
  endtask

  task automatic chk_int(input string tag, input logic v,
                         input logic [2:0] id);
    chk({tag, "_int"}, 32'(int_o), 32'(v));
    if (v) chk({tag, "_id"}, 32'(int_id), 32'(id));
  endtask

  initial begin
    n_run = 0; n_fail = 0;
    rst = 1'b1; irq = '0; req = 1'b0; we = 1'b0;
    addr = '0; wdata = '0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_int", 32'(int_o), 0);
    chk("rst_id", 32'(int_id), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_rdata", rdata, 0);
    rst = 1'b1;

    // Test 1: edge source 0, latency and claim
    wr(4'h4, 32'hF);
    pulse(0);
    chk("t1_early", 32'(int_o), 0);
    @(negedge clk);
    chk_int("t1", 1'b1, 3'd1);
    rd("t1_claim", 4'h8, 32'd1);
    chk("t1_drop", 32'(int_o), 0);
    rd("t1_stat", 4'hC, 32'h101);
    rd("t1_pend", 4'h0, 32'h0);
    wr(4'h8, 32'd1);
    rd("t1_stat2", 4'hC, 32'h0);

    // Test 2: priority, level source 3 beats edge source 0
    @(negedge clk);
    irq = 4'b1001;
    repeat (2) @(negedge clk);
    chk_int("t2", 1'b1, 3'd4);
    rd("t2_claim", 4'h8, 32'd4);
    rd("t2_stat", 4'hC, 32'h108);
    irq[3] = 1'b0;
    wr(4'h8, 32'd4);
    rd("t2_claim2", 4'h8, 32'd1);
    irq = '0;
    wr(4'h8, 32'd1);
    rd("t2_stat2", 4'hC, 32'h0);

    // Test 3: masking keeps pending
    wr(4'h4, 32'h0);
    pulse(1);
    repeat (2) @(negedge clk);
    chk("t3_mask", 32'(int_o), 0);
    rd("t3_pend", 4'h0, 32'h2);
    wr(4'h4, 32'h2);
    @(negedge clk);
    chk_int("t3", 1'b1, 3'd2);
    rd("t3_claim", 4'h8, 32'd2);
    wr(4'h8, 32'd2);
    wr(4'h4, 32'hFFFF_FFFF);
    rd("t3_en", 4'h4, 32'hF);

    // Test 4: re-latch during service, single fire after complete
    pulse(0);
    @(negedge clk);
    rd("t4_claim", 4'h8, 32'd1);
    pulse(0);
    pulse(0);
    @(negedge clk);
    chk("t4_busy", 32'(int_o), 0);
    rd("t4_pend", 4'h0, 32'h1);
    wr(4'h8, 32'd1);
    @(negedge clk);
    chk_int("t4_re", 1'b1, 3'd1);
    rd("t4_claim2", 4'h8, 32'd1);
    wr(4'h8, 32'd1);
    rd("t4_pend2", 4'h0, 32'h0);
    @(negedge clk);
    chk("t4_idle", 32'(int_o), 0);

    // Test 5: set beats W1C, wrong-ID complete ignored
    pulse(0);
    @(negedge clk);
    rd("t5_pend", 4'h0, 32'h1);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 4'h0; wdata = 32'h1; irq[0] = 1'b1;
    @(negedge clk);
    req = 1'b0; we = 1'b0; irq[0] = 1'b0;
    rd("t5_setwin", 4'h0, 32'h1);
    rd("t5_claim", 4'h8, 32'd1);
    rd("t5_stat", 4'hC, 32'h101);
    wr(4'h8, 32'd3);
    rd("t5_wrongid", 4'hC, 32'h101);
    wr(4'h8, 32'd0);
    rd("t5_id0", 4'hC, 32'h101);
    rd("t5_claimbusy", 4'h8, 32'd0);
    wr(4'h8, 32'd1);
    rd("t5_stat2", 4'hC, 32'h0);

    // W1C alone, level bit immune to W1C, unmapped addresses
    pulse(1);
    rd("w1c_pend", 4'h0, 32'h2);
    wr(4'h0, 32'h2);
    rd("w1c_clr", 4'h0, 32'h0);
    @(negedge clk);
    irq[3] = 1'b1;
    @(negedge clk);
    wr(4'h0, 32'h8);
    rd("lvl_w1c", 4'h0, 32'h8);
    irq[3] = 1'b0;
    @(negedge clk);
    rd("lvl_drop", 4'h0, 32'h0);
    wr(4'h1, 32'hFFFF_FFFF);
    rd("unmap1", 4'h1, 32'h0);
    rd("unmap6", 4'h6, 32'h0);
    rd("unmap_en", 4'h4, 32'hF);

    // Test 6: async reset mid-service
    pulse(0);
    @(negedge clk);
    rd("t6_claim", 4'h8, 32'd1);
    @(negedge clk);
    irq = 4'b0101;
    @(negedge clk);
    irq = 4'b0100;
    @(negedge clk);
    rd("t6_pend", 4'h0, 32'h5);
    chk("t6_pre_id", 32'(int_id), 32'd3);
    chk("t6_pre_int", 32'(int_o), 0);
    rst = 1'b0;
    irq = '0;
    #1;
    chk("t6_int", 32'(int_o), 0);
    chk("t6_id", 32'(int_id), 0);
    chk("t6_ack", 32'(ack), 0);
    chk("t6_rdata", rdata, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rd("t6_stat", 4'hC, 32'h0);
    rd("t6_pend2", 4'h0, 32'h0);
    rd("t6_en", 4'h4, 32'h0);
    rd("t6_claim2", 4'h8, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
